// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding the 8-bit ALU through a registered issue stage; optional ALU_CMD_QUEUE_BYPASS_EN.
// Latency: 2 edges from accept to issue (1 edge on the empty-queue bypass path when enabled).
// Backpressure: o_cmd_ready drops when storage is full or flushing; i_stall freezes the issue stage.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [7:0]    i_a,
    input  logic [7:0]    i_b,
    input  logic [2:0]    i_op_sel,
    input  logic          i_stall,
    input  logic          i_flush,
    output logic [7:0]    o_alu_a,
    output logic [7:0]    o_alu_b,
    output logic [2:0]    o_alu_op_sel,
    output logic          o_alu_valid,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    cmd_t          out_q, out_d;
    logic          vld_q, vld_d;

    cmd_t cmd_in;
    logic full, empty, ready, push, pop, bypass, store;

    assign cmd_in = cmd_t'{a: i_a, b: i_b, op: i_op_sel};
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign ready  = !full && !i_flush;
    assign push   = i_cmd_valid && ready;
    assign pop    = !i_stall && !empty && !i_flush;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
    assign bypass = empty && !i_stall && push;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed command skips storage entirely, so only non-bypass pushes count.
    assign store  = push && !bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        vld_d    = vld_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            vld_d    = 1'b0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (!i_stall) begin
                if (pop) begin
                    out_d = mem_q[rd_ptr_q];
                    vld_d = 1'b1;
                end else if (bypass) begin
                    out_d = cmd_in;
                    vld_d = 1'b1;
                end else begin
                    vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    // Storage is never cleared; pointers and count alone define what is live.
    always_ff @(posedge i_clk) begin
        if (i_rstn && store) mem_q[wr_ptr_q] <= cmd_in;
    end

    assign o_cmd_ready  = ready;
    assign o_alu_a      = out_q.a;
    assign o_alu_b      = out_q.b;
    assign o_alu_op_sel = out_q.op;
    assign o_alu_valid  = vld_q;
    assign o_count      = count_q;
    assign o_full       = full;
    assign o_empty      = empty;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: queue-based reference model plus an issue-order scoreboard.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          i_clk = 1'b0;
    logic          i_rstn, i_cmd_valid, o_cmd_ready, i_stall, i_flush;
    logic [7:0]    i_a, i_b, o_alu_a, o_alu_b;
    logic [2:0]    i_op_sel, o_alu_op_sel;
    logic          o_alu_valid, o_full, o_empty;
    logic [CW-1:0] o_count;

    always #5 i_clk = ~i_clk;

    alu_cmd_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_a(i_a), .i_b(i_b), .i_op_sel(i_op_sel), .i_stall(i_stall), .i_flush(i_flush),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op_sel(o_alu_op_sel),
        .o_alu_valid(o_alu_valid), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    int errs   = 0;
    int checks = 0;

    logic [18:0] mstore[$];   // commands held in storage, oldest first
    logic [18:0] exp_q[$];    // commands predicted to be issued, in order
    logic        mvalid = 1'b0;
    logic [18:0] mout   = '0;
    bit          init   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluated once per cycle with that cycle's inputs.
    always @(negedge i_clk) begin
        logic [18:0] in_c;
        bit          acc, pop, byp;
        in_c = {i_a, i_b, i_op_sel};
        if (init) begin
            chk("count", 32'(o_count), 32'(mstore.size()));
            chk("full", 32'(o_full), 32'(mstore.size() == DEPTH));
            chk("empty", 32'(o_empty), 32'(mstore.size() == 0));
            chk("ready", 32'(o_cmd_ready), 32'((mstore.size() != DEPTH) && !i_flush));
            chk("valid", 32'(o_alu_valid), 32'(mvalid));
            chk("out_data", 32'({o_alu_a, o_alu_b, o_alu_op_sel}), 32'(mout));
        end
        if (!i_rstn) begin
            mstore.delete();
            mvalid = 1'b0;
            mout   = '0;
            init   = 1'b1;
        end else if (i_flush) begin
            mstore.delete();
            mvalid = 1'b0;
        end else begin
            acc = i_cmd_valid && (mstore.size() < DEPTH);
            pop = !i_stall && (mstore.size() > 0);
            byp = 1'b0;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
            byp = acc && !i_stall && (mstore.size() == 0);
`endif
            if (pop) begin
                mout   = mstore.pop_front();
                mvalid = 1'b1;
                exp_q.push_back(mout);
            end else if (byp) begin
                mout   = in_c;
                mvalid = 1'b1;
                exp_q.push_back(in_c);
            end else if (!i_stall) begin
                mvalid = 1'b0;
            end
            if (acc && !byp) mstore.push_back(in_c);
        end
    end

    // Monitor: each freshly issued command must match the scoreboard head.
    bit          prev_ok   = 1'b0;
    bit          prev_hold = 1'b0;
    logic [18:0] last_iss  = '0;
    always @(negedge i_clk) begin
        logic [18:0] cur, e;
        cur = {o_alu_a, o_alu_b, o_alu_op_sel};
        if (init && o_alu_valid === 1'b1) begin
            if (prev_ok) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL issue_unexpected @%0t: got %0h expected none", $time, cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_order", 32'(cur), 32'(e));
                end
                last_iss = cur;
            end else if (prev_hold) begin
                chk("stall_hold", 32'(cur), 32'(last_iss));
            end
        end
        prev_ok   = i_rstn && !i_flush && !i_stall;
        prev_hold = i_rstn && !i_flush && i_stall;
    end

    logic [7:0] next_a;
    bit         take_new;

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        i_a = a; i_b = b; i_op_sel = op;
        take_new = 1'b0;
    endtask

    // One cycle; the producer keeps its command until it is accepted.
    task automatic cyc(input bit v, input bit st, input bit fl, input bit rs);
        if (take_new) begin
            i_a      = next_a;
            next_a   = next_a + 8'd1;
            i_b      = 8'($urandom);
            i_op_sel = 3'($urandom);
        end
        i_cmd_valid = v; i_stall = st; i_flush = fl; i_rstn = rs;
        @(negedge i_clk);
        take_new = v && rs && (o_cmd_ready === 1'b1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic restart_seq(input logic [7:0] a0);
        next_a = a0;
        take_new = 1'b1;
    endtask

    initial begin
        i_rstn = 1'b0; i_cmd_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_a = '0; i_b = '0; i_op_sel = '0;
        next_a = 8'd1; take_new = 1'b1;
        @(posedge i_clk);
        #1;

        // reset held two edges with a command offered
        set_cmd(8'h5A, 8'h00, 3'd0);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1);

        // single command, then idle
        set_cmd(8'h12, 8'h34, 3'd2);
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);

        // fill while stalled, fifth command held until space frees
        restart_seq(8'd1);
        repeat (6) cyc(1, 1, 0, 1);
        repeat (2) cyc(1, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);

        // stall for 3 cycles while A1 is on the outputs
        restart_seq(8'hA0);
        repeat (3) cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        repeat (2) cyc(0, 1, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);

        // two stored, then push and pop together across pointer wrap
        restart_seq(8'h20);
        repeat (2) cyc(1, 1, 0, 1);
        repeat (6) cyc(1, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);

        // three queued with a valid output, then flush with a command offered
        restart_seq(8'h40);
        repeat (2) cyc(1, 0, 0, 1);
        repeat (2) cyc(1, 1, 0, 1);
        cyc(1, 0, 1, 1);
        repeat (2) cyc(1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);

        // randomized traffic including occasional flush and reset
        restart_seq(8'h80);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 4) == 0,
                ($urandom % 32) == 0, ($urandom % 128) != 0);
        end
        repeat (8) cyc(0, 0, 0, 1);

        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
